// File: rtl/rst_en_pkg.sv
// Shared types and defaults for the reset/enable sequencer.
package rst_en_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HOLD = 3'd2,
    ST_POST = 3'd3,
    ST_RUN  = 3'd4
  } state_e;

  // Width of the shared hold/tail down-counter
  localparam int unsigned TMR_W = 32'd4;

  // Default number of cycles dut_rst is held high
  localparam int unsigned HOLD_CYCLES_DEF = 32'd3;

  // Default number of cycles dut_en stays high after dut_rst falls
  localparam int unsigned TAIL_CYCLES_DEF = 32'd2;

  // The timer reaches zero in the last cycle of a phase, so a phase of
  // N cycles loads N-1.
  function automatic logic [TMR_W-1:0] cycles_to_load(input int unsigned cycles);
    int unsigned val;
    val = cycles - 32'd1;
    return val[TMR_W-1:0];
  endfunction

  // States in which a sequence is in progress
  function automatic logic is_seq_state(input state_e s);
    logic r;
    case (s)
      ST_PRE, ST_HOLD, ST_POST: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rst_en_sequencer_seq_timer.sv
// Loadable down-counter with a zero flag, shared by the HOLD and POST phases.
module seq_timer
  import rst_en_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {TMR_W{1'b0}}) begin
      cnt_d = cnt_q - {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {TMR_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {TMR_W{1'b0}});

endmodule

// File: rtl/rst_en_sequencer.sv
// Reset/enable sequencer: raises dut_en ahead of dut_rst, holds dut_rst for
// HOLD_CYCLES, keeps dut_en up for TAIL_CYCLES afterwards, then hands the
// enable over to req_en. All outputs are registered.
module rst_en_sequencer
  import rst_en_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned TAIL_CYCLES = TAIL_CYCLES_DEF,
  parameter int unsigned CNT_W       = 32'd8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_rst,
  input  logic             req_en,
  output logic             dut_rst,
  output logic             dut_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] seq_cnt
);

  state_e           state_q, state_d;
  logic             dut_rst_q, dut_rst_d;
  logic             dut_en_q, dut_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;

  logic             restart_s;
  logic             tmr_load_s;
  logic [TMR_W-1:0] tmr_val_s;
  logic             tmr_zero_s;

  seq_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .zero_o     (tmr_zero_s)
  );

  // Next-state selection; a request in HOLD restarts the hold window,
  // a request in POST goes straight back to HOLD, PRE ignores requests.
  always_comb begin
    state_d   = state_q;
    restart_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_rst) state_d = ST_PRE;
        else         state_d = ST_IDLE;
      end
      ST_PRE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (req_rst) begin
          state_d   = ST_HOLD;
          restart_s = 1'b1;
        end else if (tmr_zero_s) begin
          state_d = ST_POST;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_POST: begin
        if (req_rst)         state_d = ST_HOLD;
        else if (tmr_zero_s) state_d = ST_RUN;
        else                 state_d = ST_POST;
      end
      ST_RUN: begin
        if (req_rst) state_d = ST_PRE;
        else         state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Timer reload on every state entry and on a HOLD restart
  always_comb begin
    tmr_load_s = (state_d != state_q) || restart_s;
    case (state_d)
      ST_HOLD: tmr_val_s = cycles_to_load(HOLD_CYCLES);
      ST_POST: tmr_val_s = cycles_to_load(TAIL_CYCLES);
      default: tmr_val_s = {TMR_W{1'b0}};
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    dut_rst_d = (state_d == ST_HOLD);
    busy_d    = is_seq_state(state_d);
    if (busy_d) begin
      dut_en_d = 1'b1;
    end else if (state_d == ST_RUN) begin
      dut_en_d = req_en;
    end else begin
      dut_en_d = 1'b0;
    end
    done_d = (state_q == ST_POST) && (state_d == ST_RUN);
    if (done_d) begin
      seq_cnt_d = seq_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      seq_cnt_d = seq_cnt_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      dut_rst_q <= 1'b0;
      dut_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seq_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      dut_rst_q <= dut_rst_d;
      dut_en_q  <= dut_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign dut_rst = dut_rst_q;
  assign dut_en  = dut_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign seq_cnt = seq_cnt_q;

  // dut_rst must never be seen high without dut_en, on either clock edge
  a_rst_implies_en_pos: assert property (@(posedge clk) dut_rst |-> dut_en);
  a_rst_implies_en_neg: assert property (@(negedge clk) dut_rst |-> dut_en);

  // done is a single-cycle pulse
  a_done_one_cycle: assert property (@(posedge clk) done |=> !done);

endmodule

// File: tb/tb_rst_en_sequencer.sv
// Directed bench for rst_en_sequencer (HOLD=3, TAIL=2, CNT_W=2).
module tb_rst_en_sequencer;

  logic       clk;
  logic       rst;
  logic       req_rst;
  logic       req_en;
  logic       dut_rst;
  logic       dut_en;
  logic       busy;
  logic       done;
  logic [1:0] seq_cnt;

  int n_checks;
  int n_fail;

  logic [1:0] exp_cnt [5];

  rst_en_sequencer #(
    .HOLD_CYCLES (32'd3),
    .TAIL_CYCLES (32'd2),
    .CNT_W       (32'd2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_rst (req_rst),
    .req_en  (req_en),
    .dut_rst (dut_rst),
    .dut_en  (dut_en),
    .busy    (busy),
    .done    (done),
    .seq_cnt (seq_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Advance one posedge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {dut_rst, dut_en, busy, done, seq_cnt} against the expected vector
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {dut_rst, dut_en, busy, done, seq_cnt};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b (rst,en,busy,done,cnt)", tag, obs, exp);
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b0;
    req_rst  = 1'b0;
    req_en   = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state
    step(); chk("reset", 6'b000000);
    rst = 1'b1;
    step(); chk("idle", 6'b000000);

    // Basic sequence: PRE 1, HOLD 3, POST 2, then RUN with done
    req_rst = 1'b1;
    step(); chk("pre", 6'b011000);
    req_rst = 1'b0;
    step(); chk("hold1", 6'b111000);
    step(); chk("hold2", 6'b111000);
    step(); chk("hold3", 6'b111000);
    step(); chk("post1", 6'b011000);
    step(); chk("post2", 6'b011000);
    step(); chk("run_done", 6'b000101);
    step(); chk("run", 6'b000001);

    // RUN: dut_en follows req_en one cycle later
    req_en = 1'b1; step(); chk("run_en1", 6'b010001);
    req_en = 1'b0; step(); chk("run_en0", 6'b000001);
    req_en = 1'b1; step(); chk("run_en1b", 6'b010001);

    // Request held through PRE (ignored) and into first HOLD cycle (restart)
    req_rst = 1'b1;
    step(); chk("pre_b", 6'b011001);
    step(); chk("hold_a", 6'b111001);
    step(); chk("hold_b_restart", 6'b111001);
    req_rst = 1'b0;
    // Glitch on rst between edges must have no effect
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    step(); chk("hold_c", 6'b111001);
    step(); chk("hold_d", 6'b111001);
    step(); chk("post_b1", 6'b011001);
    step(); chk("post_b2", 6'b011001);
    step(); chk("done_b", 6'b010110);

    // Request in POST returns to HOLD without dropping dut_en; PRE forces en
    req_en  = 1'b0;
    req_rst = 1'b1;
    step(); chk("pre_c_en_forced", 6'b011010);
    req_rst = 1'b0;
    step(); chk("hold_c1", 6'b111010);
    step(); chk("hold_c2", 6'b111010);
    step(); chk("hold_c3", 6'b111010);
    step(); chk("post_c1", 6'b011010);
    req_rst = 1'b1;
    step(); chk("rehold1", 6'b111010);
    req_rst = 1'b0;
    step(); chk("rehold2", 6'b111010);
    step(); chk("rehold3", 6'b111010);
    step(); chk("post_c1b", 6'b011010);
    step(); chk("post_c2b", 6'b011010);
    step(); chk("done_c", 6'b000111);

    // Reset in the middle of HOLD aborts the sequence
    req_rst = 1'b1;
    step(); chk("pre_d", 6'b011011);
    req_rst = 1'b0;
    step(); chk("hold_d1", 6'b111011);
    rst = 1'b0;
    step(); chk("mid_reset", 6'b000000);
    rst = 1'b1;
    step(); chk("after_reset1", 6'b000000);
    step(); chk("after_reset2", 6'b000000);
    step(); chk("after_reset3", 6'b000000);

    // Five sequences with a 2-bit counter: 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      req_rst = 1'b1;
      step();
      req_rst = 1'b0;
      repeat (5) step();
      step(); chk($sformatf("wrap_%0d", i), {4'b0001, exp_cnt[i]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
